// File: rtl/fp_reciprocal_iter.sv
// fp_reciprocal_iter: iterative floating-point reciprocal (1/x).
//
// The significand reciprocal is refined by Newton-Raphson from a linear seed
// using one shared multiplier (two cycles per iteration). Special operands
// (NaN, inf, zero/subnormal) bypass the datapath. Results that fall below the
// smallest normal are flushed to signed zero.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operand offered
//   in_ready   unit idle and able to accept an operand
//   in_data    operand {sign, exp, man}
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts result
//   out_data   reciprocal {sign, exp, man}
//   out_dz     operand was zero/subnormal (divide-by-zero)
//   out_uf     result underflowed to zero
module fp_reciprocal_iter #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned ITERS = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_data,
  output logic                   out_dz,
  output logic                   out_uf
);

  localparam int unsigned DW   = 1 + EXP_W + MAN_W;
  localparam int unsigned F    = MAN_W + 6;   // fraction bits of the fixed-point datapath
  localparam int unsigned W    = F + 2;       // two integer bits: values stay below 4
  localparam int unsigned PW   = 2 * W;
  localparam int unsigned GB   = F - MAN_W;   // bits below the kept mantissa
  localparam int unsigned EW   = EXP_W + 2;   // exponent math width, sign bit on top
  localparam int unsigned CntW = 3;
  localparam int unsigned BIAS = (1 << (EXP_W - 1)) - 1;

  localparam logic [CntW-1:0] IterLast = CntW'(ITERS - 1);
  localparam logic [EW-1:0]   TwoBias  = EW'(2 * BIAS);

  // Seed x0 = 48/17 - 32/17*d, constants rounded to F fraction bits.
  localparam logic [63:0] SeedC1Full = ((64'd48 << F) + 64'd8) / 64'd17;
  localparam logic [63:0] SeedC2Full = ((64'd32 << F) + 64'd8) / 64'd17;
  localparam logic [W-1:0] SeedC1 = SeedC1Full[W-1:0];
  localparam logic [W-1:0] SeedC2 = SeedC2Full[W-1:0];
  localparam logic [W-1:0] Two    = {2'b10, {F{1'b0}}};

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StClass = 3'd1;
  localparam logic [2:0] StSeed  = 3'd2;
  localparam logic [2:0] StMulA  = 3'd3;
  localparam logic [2:0] StMulB  = 3'd4;
  localparam logic [2:0] StNorm  = 3'd5;
  localparam logic [2:0] StDone  = 3'd6;

  logic [2:0]      state_q, state_d;
  logic [DW-1:0]   op_q, op_d;
  logic [W-1:0]    x_q, x_d;
  logic [W-1:0]    t_q, t_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic            out_dz_q, out_dz_d;
  logic            out_uf_q, out_uf_d;

  // Operand fields
  logic             op_sign;
  logic [EXP_W-1:0] op_exp;
  logic [MAN_W-1:0] op_man;
  logic             exp_all1, exp_zero, man_zero;

  assign op_sign  = op_q[DW-1];
  assign op_exp   = op_q[MAN_W +: EXP_W];
  assign op_man   = op_q[MAN_W-1:0];
  assign exp_all1 = &op_exp;
  assign exp_zero = (op_exp == '0);
  assign man_zero = (op_man == '0);

  // d = 0.1man in [0.5, 1)
  logic [W-1:0] d_fix;
  assign d_fix = {2'b00, 1'b1, op_man, {(GB - 1){1'b0}}};

  // Shared multiplier; operand selection follows the state.
  logic [W-1:0]  mul_a, mul_b;
  logic [PW-1:0] prod;
  logic [W-1:0]  prod_t;

  always_comb begin
    mul_a = x_q;
    mul_b = t_q;
    case (state_q)
      StSeed: begin
        mul_a = SeedC2;
        mul_b = d_fix;
      end
      StMulA: begin
        mul_a = d_fix;
        mul_b = x_q;
      end
      default: begin
        mul_a = x_q;
        mul_b = t_q;
      end
    endcase
  end

  assign prod   = {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};
  assign prod_t = prod[F +: W];

  logic unused_prod;
  assign unused_prod = ^{prod[PW-1:F+W], prod[F-1:0]};

  // Result formation from x ~= 1/d in (1, 2]
  logic [MAN_W-1:0] x_frac_hi;
  logic             guard_bit, sticky_bit, round_up;
  logic [MAN_W:0]   man_rnd;
  logic [EW-1:0]    e_ext, res_exp;
  logic [MAN_W-1:0] res_man;
  logic             norm_uf;
  logic [DW-1:0]    norm_data;

  always_comb begin
    x_frac_hi  = x_q[F-1 -: MAN_W];
    guard_bit  = x_q[GB-1];
    sticky_bit = |x_q[GB-2:0];
    round_up   = guard_bit & (sticky_bit | x_frac_hi[0]);
    man_rnd    = {1'b0, x_frac_hi} + {{MAN_W{1'b0}}, round_up};
    e_ext      = {2'b00, op_exp};
    if (man_zero) begin
      // Power of two: reciprocal is exact, iteration result unused.
      res_exp = TwoBias - e_ext;
      res_man = '0;
    end else begin
      // Rounding carry into 2.0 bumps the exponent; mantissa bits are then zero.
      res_exp = TwoBias - e_ext - EW'(1) + {{(EW - 1){1'b0}}, man_rnd[MAN_W]};
      res_man = man_rnd[MAN_W-1:0];
    end
    // Exponent math wraps; top bit set means negative.
    norm_uf = res_exp[EW-1] | (res_exp == '0);
    if (norm_uf) begin
      norm_data = {op_sign, {(EXP_W + MAN_W){1'b0}}};
    end else begin
      norm_data = {op_sign, res_exp[EXP_W-1:0], res_man};
    end
  end

  logic unused_x;
  assign unused_x = x_q[W-1] ^ x_q[W-2];

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    x_d        = x_q;
    t_d        = t_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    out_dz_d   = out_dz_q;
    out_uf_d   = out_uf_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_d    = in_data;
          state_d = StClass;
        end
      end
      StClass: begin
        out_dz_d = 1'b0;
        out_uf_d = 1'b0;
        if (exp_all1 && !man_zero) begin
          out_data_d = {op_sign, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};
          state_d    = StDone;
        end else if (exp_all1) begin
          out_data_d = {op_sign, {(EXP_W + MAN_W){1'b0}}};
          state_d    = StDone;
        end else if (exp_zero) begin
          // Subnormals are flushed, so they divide by zero as well.
          out_data_d = {op_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          out_dz_d   = 1'b1;
          state_d    = StDone;
        end else begin
          state_d = StSeed;
        end
      end
      StSeed: begin
        x_d     = SeedC1 - prod_t;
        cnt_d   = '0;
        state_d = StMulA;
      end
      StMulA: begin
        t_d     = Two - prod_t;
        state_d = StMulB;
      end
      StMulB: begin
        x_d   = prod_t;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == IterLast) begin
          state_d = StNorm;
        end else begin
          state_d = StMulA;
        end
      end
      StNorm: begin
        out_data_d = norm_data;
        out_dz_d   = 1'b0;
        out_uf_d   = norm_uf;
        state_d    = StDone;
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      op_q       <= '0;
      x_q        <= '0;
      t_q        <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
      out_dz_q   <= 1'b0;
      out_uf_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      x_q        <= x_d;
      t_q        <= t_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      out_dz_q   <= out_dz_d;
      out_uf_q   <= out_uf_d;
    end
  end

  assign in_ready  = (state_q == StIdle) && !rst;
  assign out_valid = (state_q == StDone);
  assign out_data  = out_data_q;
  assign out_dz    = out_dz_q;
  assign out_uf    = out_uf_q;

endmodule

// File: tb/tb_fp_reciprocal_iter.sv
// Self-checking bench for fp_reciprocal_iter (single precision, 3 iterations).
module tb_fp_reciprocal_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_dz;
  logic        out_uf;

  fp_reciprocal_iter #(
    .EXP_W(8),
    .MAN_W(23),
    .ITERS(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_dz   (out_dz),
    .out_uf   (out_uf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] din;
    logic [31:0] dout;
    logic        dz;
    logic        uf;
    int          tol;   // allowed ulp distance
    int          lat;   // edges from accept edge (inclusive) to out_valid
  } vec_t;

  vec_t vecs[20];
  vec_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(input logic [31:0] din, input logic [31:0] dout,
                              input logic dz, input logic uf, input int tol,
                              input int lat);
    vec_t v;
    v.din  = din;
    v.dout = dout;
    v.dz   = dz;
    v.uf   = uf;
    v.tol  = tol;
    v.lat  = lat;
    return v;
  endfunction

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_word(input string name, input logic [31:0] act,
                            input logic [31:0] exp, input int tol);
    int da, de, diff;
    checks++;
    da   = int'(act[30:0]);
    de   = int'(exp[30:0]);
    diff = (da > de) ? da - de : de - da;
    if ($isunknown(act) || act[31] !== exp[31] || diff > tol) begin
      errors++;
      $display("FAIL %s: got %h expected %h (+-%0d ulp)", name, act, exp, tol);
    end
  endtask

  // Drive one operand, optionally stall the consumer for `hold` cycles and
  // offer a stray operand while busy, then complete the handshake.
  task automatic run_op(input vec_t v, input int hold, input bit poke);
    vec_t        e;
    int          lat;
    int          bad;
    logic [31:0] held;
    check_bit($sformatf("in_ready before %h", v.din), in_ready, 1'b1);
    in_valid = 1'b1;
    in_data  = v.din;
    sb_q.push_back(v);
    @(posedge clk);
    #1;
    lat      = 1;
    in_valid = poke;
    in_data  = 32'h4000_0000;
    while (!out_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    e = sb_q.pop_front();
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL timeout for %h: out_valid still %b after %0d cycles", e.din, out_valid,
               lat);
      in_valid = 1'b0;
      return;
    end
    check_word($sformatf("data %h", e.din), out_data, e.dout, e.tol);
    check_bit($sformatf("dz %h", e.din), out_dz, e.dz);
    check_bit($sformatf("uf %h", e.din), out_uf, e.uf);
    check_int($sformatf("latency %h", e.din), lat, e.lat);
    held = out_data;
    bad  = 0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0) bad++;
    end
    if (hold > 0) check_int($sformatf("hold stable %h", e.din), bad, 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_bit($sformatf("in_ready after %h", e.din), in_ready, 1'b1);
    check_bit($sformatf("out_valid after %h", e.din), out_valid, 1'b0);
  endtask

  initial begin
    int bad;

    vecs[0]  = mk(32'h4000_0000, 32'h3F00_0000, 1'b0, 1'b0, 0, 10);
    vecs[1]  = mk(32'h3E80_0000, 32'h4080_0000, 1'b0, 1'b0, 0, 10);
    vecs[2]  = mk(32'h4040_0000, 32'h3EAA_AAAB, 1'b0, 1'b0, 1, 10);
    vecs[3]  = mk(32'hC0A0_0000, 32'hBE4C_CCCD, 1'b0, 1'b0, 1, 10);
    vecs[4]  = mk(32'h8000_0000, 32'hFF80_0000, 1'b1, 1'b0, 0, 2);
    vecs[5]  = mk(32'h0000_0001, 32'h7F80_0000, 1'b1, 1'b0, 0, 2);
    vecs[6]  = mk(32'h7F80_0000, 32'h0000_0000, 1'b0, 1'b0, 0, 2);
    vecs[7]  = mk(32'h7FC0_0001, 32'h7FC0_0000, 1'b0, 1'b0, 0, 2);
    vecs[8]  = mk(32'h7E80_0000, 32'h0080_0000, 1'b0, 1'b0, 0, 10);
    vecs[9]  = mk(32'h7E80_0001, 32'h0000_0000, 1'b0, 1'b1, 0, 10);
    vecs[10] = mk(32'h3FC0_0000, 32'h3F2A_AAAB, 1'b0, 1'b0, 1, 10);
    vecs[11] = mk(32'h4120_0000, 32'h3DCC_CCCD, 1'b0, 1'b0, 1, 10);
    vecs[12] = mk(32'h40E0_0000, 32'h3E12_4925, 1'b0, 1'b0, 1, 10);
    vecs[13] = mk(32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b0, 0, 10);
    vecs[14] = mk(32'hBF00_0000, 32'hC000_0000, 1'b0, 1'b0, 0, 10);
    vecs[15] = mk(32'hFF7F_FFFF, 32'h8000_0000, 1'b0, 1'b1, 0, 10);
    vecs[16] = mk(32'hFF80_0000, 32'h8000_0000, 1'b0, 1'b0, 0, 2);
    vecs[17] = mk(32'hFFC1_2345, 32'hFFC0_0000, 1'b0, 1'b0, 0, 2);
    vecs[18] = mk(32'h3F80_0001, 32'h3F7F_FFFE, 1'b0, 1'b0, 1, 10);
    vecs[19] = mk(32'h0080_0000, 32'h7E80_0000, 1'b0, 1'b0, 0, 10);

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_bit("reset out_valid", out_valid, 1'b0);
    check_int("reset out_data", int'(out_data), 0);
    check_bit("reset out_dz", out_dz, 1'b0);
    check_bit("reset out_uf", out_uf, 1'b0);
    check_bit("reset in_ready", in_ready, 1'b0);
    rst = 1'b0;
    #1;
    check_bit("in_ready after reset", in_ready, 1'b1);

    foreach (vecs[i]) run_op(vecs[i], 0, 1'b0);

    // Back-pressure with stray operands offered while busy.
    run_op(mk(32'h4040_0000, 32'h3EAA_AAAB, 1'b0, 1'b0, 1, 10), 5, 1'b1);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0) bad++;
    end
    check_int("no result from stray operands", bad, 0);

    // Abort a 3.0 operation in its fourth cycle.
    in_valid = 1'b1;
    in_data  = 32'h4040_0000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_bit("abort out_valid", out_valid, 1'b0);
    check_bit("abort in_ready during rst", in_ready, 1'b0);
    rst = 1'b0;
    #1;
    check_bit("abort idle in_ready", in_ready, 1'b1);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
    end
    check_int("abort produced no result", bad, 0);
    run_op(vecs[0], 0, 1'b0);

    check_int("scoreboard empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
